// File: rtl/mips_mc_core_p.sv
// Multicycle MIPS core: one shared memory port with a ready handshake, register file and control FSM.
// Stalls on mem_ready, halts on illegal opcode/funct or on an optional memory wait timeout.
module mips_mc_core_p #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          JAL_EN       = 1'b1,
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] pc,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_JAL, S_HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d, data_q, data_d, wait_cnt_q, wait_cnt_d;
  logic        halted_q, halted_d;
  logic [31:0] rf_q [32];

  logic        rf_we, mem_req;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sign_imm, zero_imm, jump_target;

  assign op          = ir_q[31:26];
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign funct       = ir_q[5:0];
  assign sign_imm    = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zero_imm    = {16'h0000, ir_q[15:0]};
  assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = rf_q[rs];
    b_d        = rf_q[rt];
    alu_out_d  = alu_out_q;
    data_d     = mem_rdata;
    wait_cnt_d = '0;
    rf_we      = 1'b0;
    rf_waddr   = rt;
    rf_wdata   = alu_out_q;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = alu_out_q;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = pc_q;
        alu_out_d = pc_q + 32'd4;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_out_d = pc_q + {sign_imm[29:0], 2'b00};
        case (op)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_RTYPE:                 state_d = S_EXEC;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          OP_J:                     state_d = S_JUMP;
          OP_JAL:                   state_d = JAL_EN ? S_JAL : S_HALT;
          default:                  state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_out_d = a_q + sign_imm;
        state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      // Recomputing the same address keeps mem_addr stable while ALUOut reloads.
      S_MEMRD: begin
        mem_read  = 1'b1;
        mem_req   = 1'b1;
        alu_out_d = a_q + sign_imm;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = data_q;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        mem_req   = 1'b1;
        alu_out_d = a_q + sign_imm;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        state_d = S_ALUWB;
        case (funct)
          FN_ADD:  alu_out_d = a_q + b_q;
          FN_SUB:  alu_out_d = a_q - b_q;
          FN_AND:  alu_out_d = a_q & b_q;
          FN_OR:   alu_out_d = a_q | b_q;
          FN_SLT:  alu_out_d = {31'd0, $signed(a_q) < $signed(b_q)};
          default: state_d   = S_HALT;
        endcase
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        state_d  = S_FETCH;
      end
      S_IMMEX: begin
        case (op)
          OP_ADDI: alu_out_d = a_q + sign_imm;
          OP_ANDI: alu_out_d = a_q & zero_imm;
          default: alu_out_d = a_q | zero_imm;
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      // ALUOut still holds the target computed in DECODE.
      S_BRANCH: begin
        alu_out_d = a_q - b_q;
        if ((op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q)) pc_d = alu_out_q;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = jump_target;
        state_d = S_FETCH;
      end
      S_JAL: begin
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        rf_wdata = pc_q;
        pc_d     = jump_target;
        state_d  = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase

    if (mem_req && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 32'd1;
      if (MEM_WAIT_MAX != 32'd0 && wait_cnt_d == MEM_WAIT_MAX) state_d = S_HALT;
    end

    halted_d = (state_d == S_HALT);

    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign halted    = halted_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_out_q  <= '0;
      data_q     <= '0;
      wait_cnt_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_out_q  <= alu_out_d;
      data_q     <= data_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= halted_d;
    end
  end

  // NOTE: the register file is cleared on reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule
